cpu_ctrl: RTL and testbench

//  Multi-cycle control FSM sequencing the cpu datapath: fetch, decode, execute, memory, writeback.

---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/cpu_ctrl.sv | 147 ++++++++++++++
 tb/tb_cpu_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg : opcode, ALU, PC-source encodings and FSM states for cpu_ctrl
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

  // Address-forming instructions share the adder with the immediate operand.
  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB, OP_BEQ: return ALU_SUB;
      OP_AND:         return ALU_AND;
      OP_OR:          return ALU_OR;
      default:        return ALU_ADD;
    endcase
  endfunction

  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl : multi-cycle control FSM (fetch/decode/exec/mem/writeback)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               ir_we,
  output logic               mdr_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_imm,
  output logic               reg_we,
  output logic               wb_sel,
  output logic               halted,
  output logic               illegal
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic             illegal_q, illegal_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    mdr_we      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_INC;
    alu_op      = '0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;

    // ALU controls stay stable from EXEC until the instruction retires.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_op      = ALUOP_W'(alu_op_of(4'(op_q)));
      alu_src_imm = uses_imm(4'(op_q));
    end

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        op_d = opcode;
        if (4'(opcode) == OP_NOP) begin
          state_d = S_FETCH;
        end else if (4'(opcode) == OP_JMP) begin
          pc_we   = 1'b1;
          pc_src  = PC_JUMP;
          state_d = S_FETCH;
        end else if (4'(opcode) == OP_HALT) begin
          state_d = S_HALT;
        end else if (is_illegal(4'(opcode))) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (4'(op_q))
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = S_WB;
          OP_LD, OP_ST:                           state_d = S_MEM;
          OP_BEQ: begin
            if (zero) begin
              pc_we  = 1'b1;
              pc_src = PC_BRANCH;
            end
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (4'(op_q) == OP_ST);
        if (mem_ack) begin
          if (4'(op_q) == OP_LD) begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (4'(op_q) == OP_LD);
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_RESET;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl : table-driven and randomized checks of cpu_ctrl against an
//               instruction-level reference model
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero, mem_ack;
  logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_src_imm, reg_we, wb_sel, halted, illegal;

  cpu_ctrl #(.OPC_W(4), .ALUOP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       reg_we;
    logic       wb_sel;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic       ack;
    logic [3:0] opc;
    logic       z;
    out_t       exp;
  } cyc_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         fw;
    int         mw;
    int         cycles;
    int         regwe;
    int         pcwe;
  } vec_t;

  int   vecs = 0;
  int   miscompares = 0;
  int   regwe_seen, pcwe_seen;
  cyc_t mq[$];

  function automatic out_t sample();
    out_t a;
    a = '{mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src, alu_op,
          alu_src_imm, reg_we, wb_sel, halted, illegal};
    return a;
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic cyc_t mk(input logic ack, input logic [3:0] opc, input logic z, input out_t e);
    cyc_t c;
    c.ack = ack; c.opc = opc; c.z = z; c.exp = e;
    return c;
  endfunction

  function automatic out_t fetch_wait();
    out_t o = '0;
    o.mem_req = 1'b1;
    return o;
  endfunction

  // Instruction-level reference: list of per-cycle inputs and expected outputs.
  function automatic void build(input logic [3:0] op, input logic z, input int fw, input int mw);
    out_t       o;
    logic [2:0] aop;
    logic       imm, is_ld, is_st;
    mq.delete();
    for (int i = 0; i < fw; i++) mq.push_back(mk(1'b0, rnd4(), rnd1(), fetch_wait()));
    o = fetch_wait(); o.ir_we = 1'b1; o.pc_we = 1'b1;
    mq.push_back(mk(1'b1, rnd4(), rnd1(), o));
    o = '0;
    if (op == 4'h9) begin o.pc_we = 1'b1; o.pc_src = 2'd2; end
    mq.push_back(mk(rnd1(), op, rnd1(), o));
    if (op == 4'h0 || op == 4'h9) return;
    aop   = (op == 4'h2 || op == 4'h8) ? 3'd1 : (op == 4'h3) ? 3'd2 : (op == 4'h4) ? 3'd3 : 3'd0;
    imm   = (op == 4'h5 || op == 4'h6 || op == 4'h7);
    is_ld = (op == 4'h6);
    is_st = (op == 4'h7);
    o = '0; o.alu_op = aop; o.alu_src_imm = imm;
    if (op == 4'h8 && z) begin o.pc_we = 1'b1; o.pc_src = 2'd1; end
    mq.push_back(mk(rnd1(), rnd4(), (op == 4'h8) ? z : rnd1(), o));
    if (op == 4'h8) return;
    if (is_ld || is_st) begin
      o = '0; o.alu_op = aop; o.alu_src_imm = imm;
      o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = is_st;
      for (int i = 0; i < mw; i++) mq.push_back(mk(1'b0, rnd4(), rnd1(), o));
      o.mdr_we = is_ld;
      mq.push_back(mk(1'b1, rnd4(), rnd1(), o));
      if (is_st) return;
    end
    o = '0; o.alu_op = aop; o.alu_src_imm = imm; o.reg_we = 1'b1; o.wb_sel = is_ld;
    mq.push_back(mk(rnd1(), rnd4(), rnd1(), o));
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step(input cyc_t c, input string name);
    @(posedge clk);
    #1;
    mem_ack = c.ack; opcode = c.opc; zero = c.z;
    @(negedge clk);
    check(name, c.exp);
    regwe_seen += int'(reg_we);
    pcwe_seen  += int'(pc_we);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw,
                           input int cycles, input int exp_regwe, input int exp_pcwe);
    int n;
    build(op, z, fw, mw);
    n = (cycles < 0) ? mq.size() : cycles;
    regwe_seen = 0;
    pcwe_seen  = 0;
    for (int i = 0; i < n; i++)
      step((i < mq.size()) ? mq[i] : mk(1'b0, rnd4(), rnd1(), fetch_wait()),
           $sformatf("op%0h_cyc%0d", op, i));
    if (exp_regwe >= 0) begin
      vecs++;
      if (regwe_seen != exp_regwe || pcwe_seen != exp_pcwe) begin
        miscompares++;
        $display("FAIL op%0h_pulses: got reg_we=%0d pc_we=%0d required reg_we=%0d pc_we=%0d",
                 op, regwe_seen, pcwe_seen, exp_regwe, exp_pcwe);
      end
    end
    // Back in FETCH exactly when the instruction latency has elapsed.
    step(mk(1'b0, rnd4(), rnd1(), fetch_wait()), $sformatf("op%0h_land", op));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b0;
    #1 check({name, "_held"}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1 check({name, "_idle"}, '0);
  endtask

  vec_t tbl[11];
  out_t o;

  initial begin
    rst = 1'b1; opcode = 4'h0; zero = 1'b0; mem_ack = 1'b0;
    tbl[0]  = '{4'h0, 1'b0, 0, 0, 2, 0, 1};
    tbl[1]  = '{4'h1, 1'b0, 0, 0, 4, 1, 1};
    tbl[2]  = '{4'h2, 1'b1, 1, 0, 5, 1, 1};
    tbl[3]  = '{4'h3, 1'b0, 0, 0, 4, 1, 1};
    tbl[4]  = '{4'h4, 1'b0, 2, 0, 6, 1, 1};
    tbl[5]  = '{4'h5, 1'b0, 0, 0, 4, 1, 1};
    tbl[6]  = '{4'h6, 1'b0, 0, 3, 8, 1, 1};
    tbl[7]  = '{4'h7, 1'b0, 0, 1, 5, 0, 1};
    tbl[8]  = '{4'h8, 1'b1, 0, 0, 3, 0, 2};
    tbl[9]  = '{4'h8, 1'b0, 0, 0, 3, 0, 1};
    tbl[10] = '{4'h9, 1'b0, 0, 0, 2, 0, 2};

    #12 check("reset_state", '0);
    do_reset("rst0");

    foreach (tbl[i])
      run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, tbl[i].cycles, tbl[i].regwe, tbl[i].pcwe);

    for (int k = 0; k < 40; k++)
      run_instr(4'($urandom_range(0, 9)), rnd1(), $urandom_range(0, 2), $urandom_range(0, 2), -1, -1, -1);

    // Illegal opcode halts the core; later acks and opcodes change nothing.
    build(4'hB, 1'b0, 0, 0);
    step(mq[0], "ill_fetch");
    step(mq[1], "ill_decode");
    o = '0; o.halted = 1'b1; o.illegal = 1'b1;
    for (int i = 0; i < 5; i++) step(mk(1'b1, rnd4(), rnd1(), o), "ill_halted");

    do_reset("rst_ill");

    // HALT opcode stops the core without flagging illegal.
    build(4'hF, 1'b0, 0, 0);
    step(mq[0], "halt_fetch");
    step(mq[1], "halt_decode");
    o = '0; o.halted = 1'b1;
    for (int i = 0; i < 3; i++) step(mk(rnd1(), rnd4(), rnd1(), o), "halt_hold");

    do_reset("rst_halt");

    // Reset asserted mid-MEM must drop mem_req without waiting for a clock edge.
    build(4'h6, 1'b0, 0, 5);
    for (int i = 0; i < 4; i++) step(mq[i], "ld_to_mem");
    #2 rst = 1'b1;
    #1 check("rst_mid_mem", '0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_mid_mem_idle", '0);
    step(mk(1'b0, rnd4(), rnd1(), fetch_wait()), "post_reset_fetch");
    run_instr(4'h1, 1'b0, 0, 0, 4, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
